// File: rtl/fetch_decode_pkg.sv
// Shared definitions for the fetch/decode front end: widths, instruction field
// positions, encoding constants, opcode mnemonics and FSM states.
package fetch_decode_pkg;

    localparam int PC_W_DEF   = 10;
    localparam int INSTR_W    = 9;
    localparam int OP_W       = 5;
    localparam int FIELD_W    = 6;

    localparam int TYPE_MSB   = 8;
    localparam int TYPE_LSB   = 7;
    localparam int FUNCT4_MSB = 6;
    localparam int FUNCT4_LSB = 3;
    localparam int SUBOP_MSB  = 6;
    localparam int SUBOP_LSB  = 5;
    localparam int IV_OP_BIT  = 6;

    localparam logic [1:0] typeI   = 2'b00;
    localparam logic [1:0] typeII  = 2'b01;
    localparam logic [1:0] typeIII = 2'b10;
    localparam logic [1:0] typeIV  = 2'b11;

    localparam logic [3:0] iAdd   = 4'd0;
    localparam logic [3:0] iMover = 4'd1;
    localparam logic [3:0] iMovea = 4'd2;
    localparam logic [3:0] iRxor  = 4'd3;
    localparam logic [3:0] iLut   = 4'd4;
    localparam logic [3:0] iXor   = 4'd5;
    localparam logic [3:0] iAnd   = 4'd6;
    localparam logic [3:0] iLoad  = 4'd7;
    localparam logic [3:0] iStore = 4'd8;
    localparam logic [3:0] iHalt  = 4'd9;

    localparam logic [1:0] iiBeq   = 2'b00;
    localparam logic [1:0] iiBlt   = 2'b01;
    localparam logic [1:0] iiiAndi = 2'b00;
    localparam logic [1:0] iiiAddi = 2'b01;
    localparam logic [1:0] iiiSub  = 2'b10;
    localparam logic [1:0] iiiJump = 2'b11;
    localparam logic       ivLsr   = 1'b0;
    localparam logic       ivRsr   = 1'b1;

    typedef enum logic [OP_W-1:0] {
        LSR   = 5'd0,
        RSR   = 5'd1,
        ADD   = 5'd2,
        MOVER = 5'd3,
        MOVEA = 5'd4,
        RXOR  = 5'd5,
        LUT   = 5'd6,
        XOR   = 5'd7,
        AND   = 5'd8,
        LOAD  = 5'd9,
        STORE = 5'd10,
        HALT  = 5'd11,
        BEQ   = 5'd12,
        BLT   = 5'd13,
        ANDI  = 5'd14,
        ADDI  = 5'd15,
        SUB   = 5'd16,
        JUMP  = 5'd17
    } op_mne_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        WAIT   = 3'd2,
        ISSUE  = 3'd3,
        HALTED = 3'd4
    } fd_state_e;

endpackage

// File: rtl/fetch_decode_decoder.sv
// Combinational instruction decoder: 9-bit word -> mnemonic, zero-extended
// operand field and an illegal-encoding flag (illegal words map to HALT).
module instr_decoder
    import fetch_decode_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    output op_mne_e            opMne,
    output logic [FIELD_W-1:0] field,
    output logic               illegal
);

    // Type-directed decode of opcode and operand field
    always_comb begin
        opMne   = HALT;
        field   = {FIELD_W{1'b0}};
        illegal = 1'b0;
        case (instr[TYPE_MSB:TYPE_LSB])
            typeI: begin
                field = {3'b000, instr[2:0]};
                case (instr[FUNCT4_MSB:FUNCT4_LSB])
                    iAdd:    opMne = ADD;
                    iMover:  opMne = MOVER;
                    iMovea:  opMne = MOVEA;
                    iRxor:   opMne = RXOR;
                    iLut:    opMne = LUT;
                    iXor:    opMne = XOR;
                    iAnd:    opMne = AND;
                    iLoad:   opMne = LOAD;
                    iStore:  opMne = STORE;
                    iHalt:   opMne = HALT;
                    default: begin
                        opMne   = HALT;
                        illegal = 1'b1;
                    end
                endcase
            end
            typeII: begin
                field = {1'b0, instr[4:0]};
                case (instr[SUBOP_MSB:SUBOP_LSB])
                    iiBeq:   opMne = BEQ;
                    iiBlt:   opMne = BLT;
                    default: begin
                        opMne   = HALT;
                        illegal = 1'b1;
                    end
                endcase
            end
            typeIII: begin
                field = {1'b0, instr[4:0]};
                case (instr[SUBOP_MSB:SUBOP_LSB])
                    iiiAndi: opMne = ANDI;
                    iiiAddi: opMne = ADDI;
                    iiiSub:  opMne = SUB;
                    iiiJump: opMne = JUMP;
                    default: opMne = HALT;
                endcase
            end
            typeIV: begin
                field = instr[5:0];
                if (instr[IV_OP_BIT] == ivRsr) begin
                    opMne = RSR;
                end else begin
                    opMne = LSR;
                end
            end
            default: begin
                opMne   = HALT;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/fetch_decode.sv
// Fetch/decode front end: owns the PC, reads a 1-cycle-latency ROM, issues decoded ops
// over valid/ready. Optional macro FETCH_DECODE_ILLEGAL_TRAP_EN traps illegal encodings.
module fetch_decode
    import fetch_decode_pkg::*;
#(
    parameter int PC_W = PC_W_DEF
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               Start,
    input  logic [PC_W-1:0]    StartAddr,
    output logic               IMemRdEn,
    output logic [PC_W-1:0]    IMemAddr,
    input  logic [INSTR_W-1:0] IMemData,
    output logic               OpValid,
    input  logic               OpReady,
    output op_mne_e            Op,
    output logic [FIELD_W-1:0] Field,
    output logic [PC_W-1:0]    OpPC,
    input  logic               BranchTaken,
    input  logic [PC_W-1:0]    BranchTarget,
    output logic               Halted,
    output logic               Illegal
);

    fd_state_e          state_r, nextState_s;
    logic [PC_W-1:0]    pc_r, nextPc_s, opPc_r, nextOpPc_s;
    logic               opValid_r, nextOpValid_s;
    logic               halted_r, nextHalted_s, illegal_r, nextIllegal_s;
    op_mne_e            op_r, nextOp_s, decOp_s;
    logic [FIELD_W-1:0] field_r, nextField_s, decField_s;
    logic               decIllegal_s, trap_s, rdEn_s;

    instr_decoder uDecoder (
        .instr   (IMemData),
        .opMne   (decOp_s),
        .field   (decField_s),
        .illegal (decIllegal_s)
    );

`ifdef FETCH_DECODE_ILLEGAL_TRAP_EN
    assign trap_s = decIllegal_s;
`else
    assign trap_s = decIllegal_s & 1'b0;
`endif

    // Next-state, next-register and ROM-strobe logic; Start beats redirect, redirect beats handshake
    always_comb begin
        nextState_s   = state_r;
        nextPc_s      = pc_r;
        nextOpValid_s = opValid_r;
        nextOp_s      = op_r;
        nextField_s   = field_r;
        nextOpPc_s    = opPc_r;
        nextHalted_s  = halted_r;
        nextIllegal_s = illegal_r;
        rdEn_s        = 1'b0;
        if (Start) begin
            nextState_s   = FETCH;
            nextPc_s      = StartAddr;
            nextOpValid_s = 1'b0;
            nextHalted_s  = 1'b0;
            nextIllegal_s = 1'b0;
            rdEn_s        = (state_r == FETCH);
        end else begin
            case (state_r)
                IDLE: nextState_s = IDLE;
                FETCH: begin
                    // the read still goes out; a redirect just ignores its data
                    rdEn_s = 1'b1;
                    if (BranchTaken) begin
                        nextPc_s    = BranchTarget;
                        nextState_s = FETCH;
                    end else begin
                        nextState_s = WAIT;
                    end
                end
                WAIT: begin
                    if (BranchTaken) begin
                        nextPc_s    = BranchTarget;
                        nextState_s = FETCH;
                    end else if (trap_s) begin
                        nextOpPc_s    = pc_r;
                        nextHalted_s  = 1'b1;
                        nextIllegal_s = 1'b1;
                        nextState_s   = HALTED;
                    end else begin
                        nextOp_s      = decOp_s;
                        nextField_s   = decField_s;
                        nextOpPc_s    = pc_r;
                        nextOpValid_s = 1'b1;
                        nextPc_s      = pc_r + {{(PC_W-1){1'b0}}, 1'b1};
                        nextState_s   = ISSUE;
                    end
                end
                ISSUE: begin
                    if (BranchTaken) begin
                        nextOpValid_s = 1'b0;
                        nextPc_s      = BranchTarget;
                        nextState_s   = FETCH;
                    end else if (OpReady && (op_r == HALT)) begin
                        nextOpValid_s = 1'b0;
                        nextHalted_s  = 1'b1;
                        nextState_s   = HALTED;
                    end else if (OpReady) begin
                        nextOpValid_s = 1'b0;
                        rdEn_s        = 1'b1;
                        nextState_s   = WAIT;
                    end else begin
                        nextState_s = ISSUE;
                    end
                end
                HALTED:  nextState_s = HALTED;
                default: nextState_s = IDLE;
            endcase
        end
    end

    // State, PC and issued-op registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r   <= IDLE;
            pc_r      <= {PC_W{1'b0}};
            opValid_r <= 1'b0;
            op_r      <= LSR;
            field_r   <= {FIELD_W{1'b0}};
            opPc_r    <= {PC_W{1'b0}};
            halted_r  <= 1'b0;
            illegal_r <= 1'b0;
        end else begin
            state_r   <= nextState_s;
            pc_r      <= nextPc_s;
            opValid_r <= nextOpValid_s;
            op_r      <= nextOp_s;
            field_r   <= nextField_s;
            opPc_r    <= nextOpPc_s;
            halted_r  <= nextHalted_s;
            illegal_r <= nextIllegal_s;
        end
    end

    assign IMemRdEn = rdEn_s;
    assign IMemAddr = pc_r;
    assign OpValid  = opValid_r;
    assign Op       = op_r;
    assign Field    = field_r;
    assign OpPC     = opPc_r;
    assign Halted   = halted_r;
    assign Illegal  = illegal_r;

endmodule

// File: tb/tb_fetch_decode.sv
// Self-checking bench for fetch_decode: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level reference model.
module tb_fetch_decode;
    import fetch_decode_pkg::*;

    localparam int PCW = PC_W_DEF;

`ifdef FETCH_DECODE_ILLEGAL_TRAP_EN
    localparam bit TRAP_ON = 1'b1;
`else
    localparam bit TRAP_ON = 1'b0;
`endif

    logic            Clk = 1'b0;
    logic            Reset_n, Start, OpReady, BranchTaken;
    logic [PCW-1:0]  StartAddr, BranchTarget;
    logic            IMemRdEn, OpValid, Halted, Illegal;
    logic [PCW-1:0]  IMemAddr, OpPC;
    logic [8:0]      IMemData;
    op_mne_e         Op;
    logic [5:0]      Field;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    fetch_decode dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .StartAddr(StartAddr),
        .IMemRdEn(IMemRdEn), .IMemAddr(IMemAddr), .IMemData(IMemData),
        .OpValid(OpValid), .OpReady(OpReady), .Op(Op), .Field(Field), .OpPC(OpPC),
        .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
        .Halted(Halted), .Illegal(Illegal)
    );

    // Instruction ROM with one-cycle read latency
    logic [8:0]     rom [0:1023];
    logic           reqEn = 1'b0;
    logic [PCW-1:0] reqAddr = '0;
    always @(negedge Clk) begin
        reqEn   <= IMemRdEn;
        reqAddr <= IMemAddr;
    end
    always @(posedge Clk) begin
        if (reqEn) IMemData <= rom[reqAddr];
    end

    // Reference decode tables
    op_mne_e tabI   [10] = '{ADD, MOVER, MOVEA, RXOR, LUT, XOR, AND, LOAD, STORE, HALT};
    op_mne_e tabIII [4]  = '{ANDI, ADDI, SUB, JUMP};

    function automatic bit refBad(input logic [8:0] w);
        return (w[8:7] == 2'b00 && w[6:3] > 4'd9) || (w[8:7] == 2'b01 && w[6]);
    endfunction

    function automatic op_mne_e refOp(input logic [8:0] w);
        if (refBad(w)) return HALT;
        case (w[8:7])
            2'b00:   return tabI[w[6:3]];
            2'b01:   return w[5] ? BLT : BEQ;
            2'b10:   return tabIII[w[6:5]];
            default: return w[6] ? RSR : LSR;
        endcase
    endfunction

    function automatic logic [5:0] refField(input logic [8:0] w);
        case (w[8:7])
            2'b00:   return {3'b000, w[2:0]};
            2'b11:   return w[5:0];
            default: return {1'b0, w[4:0]};
        endcase
    endfunction

    // Reference model: which step of the fetch pipeline is pending, held op, sticky flags
    bit             mActive, mHalted, mIllegal, mNeedFetch, mRdPend, mValid;
    logic [PCW-1:0] mPc, mRdAddr, mOpPc;
    op_mne_e        mOp;
    logic [5:0]     mField;

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            mActive <= 0; mHalted <= 0; mIllegal <= 0; mNeedFetch <= 0; mRdPend <= 0;
            mValid <= 0; mPc <= '0; mRdAddr <= '0; mOpPc <= '0; mOp <= LSR; mField <= '0;
        end else if (Start) begin
            mActive <= 1; mPc <= StartAddr; mValid <= 0; mHalted <= 0; mIllegal <= 0;
            mRdPend <= 0; mNeedFetch <= 1;
        end else if (mActive && !mHalted) begin
            if (BranchTaken) begin
                mPc <= BranchTarget; mValid <= 0; mRdPend <= 0; mNeedFetch <= 1;
            end else if (mNeedFetch) begin
                mNeedFetch <= 0; mRdPend <= 1; mRdAddr <= mPc;
            end else if (mRdPend) begin
                mRdPend <= 0;
                if (TRAP_ON && refBad(rom[mRdAddr])) begin
                    mHalted <= 1; mIllegal <= 1; mOpPc <= mRdAddr;
                end else begin
                    mValid <= 1; mOp <= refOp(rom[mRdAddr]); mField <= refField(rom[mRdAddr]);
                    mOpPc <= mRdAddr; mPc <= mPc + 10'd1;
                end
            end else if (mValid && OpReady) begin
                mValid <= 0;
                if (mOp == HALT) mHalted <= 1;
                else begin mRdPend <= 1; mRdAddr <= mPc; end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of DUT outputs against the model
    always @(negedge Clk) begin
        if (Reset_n) begin
            chk("rdEn", IMemRdEn,
                mNeedFetch || (mValid && OpReady && mOp != HALT && !BranchTaken && !Start));
            chk("addr", IMemAddr, mPc);
            chk("valid", OpValid, mValid);
            if (mValid) begin
                chk("op", Op, mOp);
                chk("field", Field, mField);
                chk("oppc", OpPC, mOpPc);
            end
            if (mIllegal) chk("trap_pc", OpPC, mOpPc);
            chk("halted", Halted, mHalted);
            chk("illegal", Illegal, mIllegal);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #2;
    endtask

    task automatic pulseStart(input logic [PCW-1:0] a);
        StartAddr = a; Start = 1'b1;
        tick(1);
        Start = 1'b0;
    endtask

    initial begin
        int nIss, gapBad, saw30;
        logic [PCW-1:0] pcs [3];
        int cyc [3];
        op_mne_e hOp; logic [5:0] hField; logic [PCW-1:0] hPc;

        Reset_n = 0; Start = 0; OpReady = 0; BranchTaken = 0;
        StartAddr = '0; BranchTarget = '0; IMemData = '0;
        for (int i = 0; i < 1024; i++) rom[i] = 9'b00_1001_000;
        tick(2);
        chk("rst_valid", OpValid, 1'b0);
        chk("rst_rden", IMemRdEn, 1'b0);
        chk("rst_op", Op, LSR);
        Reset_n = 1;
        tick(1);

        // 1: first issue two cycles after Start
        rom[10'h010] = 9'b00_0000_011;
        OpReady = 1;
        pulseStart(10'h010);
        tick(1);
        chk("t1_wait", OpValid, 1'b0);
        tick(1);
        chk("t1_valid", OpValid, 1'b1);
        chk("t1_op", Op, ADD);
        chk("t1_field", Field, 6'd3);
        chk("t1_pc", OpPC, 10'h010);
        tick(4);

        // 2: ADDI 5, LSR 7, HALT back to back
        rom[10'h020] = 9'b10_01_00101;
        rom[10'h021] = 9'b11_0_000111;
        rom[10'h022] = 9'b00_1001_000;
        pulseStart(10'h020);
        nIss = 0;
        for (int k = 1; k < 20; k++) begin
            if (OpValid && OpReady && nIss < 3) begin
                pcs[nIss] = OpPC; cyc[nIss] = k;
                if (nIss == 0) begin
                    chk("t2_op0", Op, ADDI); chk("t2_f0", Field, 6'd5);
                end
                if (nIss == 1) begin
                    chk("t2_op1", Op, LSR); chk("t2_f1", Field, 6'h07);
                end
                nIss++;
            end
            tick(1);
        end
        chk("t2_count", nIss, 3);
        gapBad = 0;
        for (int i = 0; i < 3; i++) if (i < nIss && pcs[i] != 10'h020 + i) gapBad++;
        for (int i = 1; i < 3; i++) if (i < nIss && cyc[i] - cyc[i-1] != 2) gapBad++;
        chk("t2_seq", gapBad, 0);
        chk("t2_halted", Halted, 1'b1);
        chk("t2_rden", IMemRdEn, 1'b0);

        // 3: back-pressure holds the op and suppresses fetch
        rom[10'h040] = 9'b01_01_10101;
        OpReady = 0;
        pulseStart(10'h040);
        tick(2);
        chk("t3_op", Op, BLT); chk("t3_field", Field, 6'd21); chk("t3_pc", OpPC, 10'h040);
        hOp = Op; hField = Field; hPc = OpPC;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("t3_hold", {OpValid, IMemRdEn, Op, Field, OpPC}, {1'b1, 1'b0, hOp, hField, hPc});
        end
        OpReady = 1;
        #1;
        chk("t3_rel_rden", IMemRdEn, 1'b1);
        chk("t3_rel_addr", IMemAddr, 10'h041);
        tick(6);

        // 4: redirect during WAIT drops the pending instruction
        rom[10'h030] = 9'b00_0000_001;
        rom[10'h005] = 9'b00_0101_010;
        pulseStart(10'h030);
        tick(1);
        BranchTaken = 1; BranchTarget = 10'h005;
        tick(1);
        BranchTaken = 0;
        saw30 = 0; nIss = 0;
        for (int k = 0; k < 10 && nIss == 0; k++) begin
            if (OpValid) begin
                nIss = 1;
                if (OpPC == 10'h030) saw30 = 1;
                chk("t4_pc", OpPC, 10'h005);
                chk("t4_op", Op, XOR);
            end
            tick(1);
        end
        chk("t4_issued", nIss, 1);
        chk("t4_no30", saw30, 0);
        tick(6);

        // 5: PC wrap at the top of memory, then async reset mid-ISSUE
        rom[10'h3FF] = 9'b00_0000_001;
        OpReady = 0;
        pulseStart(10'h3FF);
        tick(2);
        chk("t5_pc", OpPC, 10'h3FF);
        chk("t5_wrap", IMemAddr, 10'h000);
        OpReady = 1;
        #1;
        chk("t5_rden", IMemRdEn, 1'b1);
        chk("t5_addr", IMemAddr, 10'h000);
        OpReady = 0; Reset_n = 0;
        #1;
        chk("t5_rst_valid", OpValid, 1'b0);
        chk("t5_rst_rden", IMemRdEn, 1'b0);
        tick(1);
        Reset_n = 1;
        tick(2);
        chk("t5_idle_rden", IMemRdEn, 1'b0);

        // 6: illegal typeI funct4
        rom[10'h050] = 9'b00_1100_000;
        pulseStart(10'h050);
        tick(2);
        if (TRAP_ON) begin
            chk("t6_valid", OpValid, 1'b0);
            chk("t6_illegal", Illegal, 1'b1);
            chk("t6_halted", Halted, 1'b1);
            chk("t6_pc", OpPC, 10'h050);
        end else begin
            chk("t6_valid", OpValid, 1'b1);
            chk("t6_op", Op, HALT);
            chk("t6_illegal", Illegal, 1'b0);
        end
        OpReady = 1;
        tick(3);
        chk("t6_end_halted", Halted, 1'b1);

        // Randomized traffic against the model
        for (int i = 0; i < 1024; i++) rom[i] = 9'($urandom);
        for (int c = 0; c < 3000; c++) begin
            OpReady      = ($urandom_range(0, 3) != 0);
            BranchTaken  = ($urandom_range(0, 15) == 0);
            BranchTarget = 10'($urandom_range(0, 1023));
            Start        = ($urandom_range(0, 63) == 0) || (Halted && $urandom_range(0, 3) == 0);
            StartAddr    = 10'($urandom_range(0, 1023));
            tick(1);
        end
        Start = 0; BranchTaken = 0; OpReady = 0;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
